score_time_display: RTL and testbench

Seven-segment display driver directly downstream of the whack-a-mole countdown timer. It consumes the timer's `seconds` and `game_over` outputs plus the running score. It time-multiplexes four digits on the board's common-anode display: seconds on the left pair, score on the right pair. On game over the seconds pair blinks.

---
 rtl/display_pkg.sv | 43 ++++
 rtl/seg7_decode.sv | 29 ++
 rtl/score_time_display.sv | 102 ++++++++++
 tb/tb_score_time_display.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the score/time seven-segment display: active-low segment
// patterns, digit-slot encoding and a small BCD split helper.
package display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] DIG_SEC_TENS = 2'd3;
  localparam logic [1:0] DIG_SEC_ONES = 2'd2;
  localparam logic [1:0] DIG_SCR_TENS = 2'd1;
  localparam logic [1:0] DIG_SCR_ONES = 2'd0;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Divide by ten with repeated compare/subtract; valid for inputs 0..99.
  function automatic bcd_t split10(input logic [6:0] v);
    bcd_t       b;
    logic [6:0] r;
    r      = v;
    b.tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (r >= 7'd10) begin
        r      = r - 7'd10;
        b.tens = b.tens + 4'd1;
      end
    end
    b.ones = r[3:0];
    return b;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low {g,f,e,d,c,b,a} pattern, with a blank override.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_time_display.sv
// Four-digit multiplexed display: seconds on the left pair, clamped score on the
// right pair; the seconds pair blinks while game_over is high.
module score_time_display
  import display_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100_000,
  parameter int BLINK_CYCLES   = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] seconds,
  input  logic       game_over,
  input  logic [6:0] score,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYCLES - 1);

  logic [4:0]    sec_q;
  logic [6:0]    score_q;
  logic          go_q;
  logic [CW-1:0] c;
  logic [1:0]    d;
  logic [BW-1:0] bc;
  logic          blink_on;

  logic [6:0] score_cl;
  bcd_t       sec_bcd, scr_bcd;
  logic [3:0] digit;
  logic       blank;
  logic [6:0] seg_nx;
  logic [3:0] an_nx;
  logic       dp_nx;

  assign score_cl = (score_q > 7'd99) ? 7'd99 : score_q;
  assign sec_bcd  = split10({2'b00, sec_q});
  assign scr_bcd  = split10(score_cl);

  always_comb begin
    digit = 4'd0;
    blank = 1'b1;
    case (d)
      DIG_SEC_TENS: begin digit = sec_bcd.tens; blank = (sec_bcd.tens == 4'd0) || !blink_on; end
      DIG_SEC_ONES: begin digit = sec_bcd.ones; blank = !blink_on; end
      DIG_SCR_TENS: begin digit = scr_bcd.tens; blank = (scr_bcd.tens == 4'd0); end
      default:      begin digit = scr_bcd.ones; blank = 1'b0; end
    endcase
  end

  seg7_decode u_dec (.bcd(digit), .blank(blank), .seg(seg_nx));

  // The seconds pair goes fully dark in the blink-off phase; the decimal point
  // stays tied to the slot so the anode alone hides it.
  always_comb begin
    an_nx = ~(4'b0001 << d);
    if (!blink_on && (d == DIG_SEC_TENS || d == DIG_SEC_ONES)) an_nx = 4'b1111;
    dp_nx = (d != DIG_SEC_ONES);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sec_q    <= '0;
      score_q  <= '0;
      go_q     <= 1'b0;
      c        <= '0;
      d        <= DIG_SEC_TENS;
      bc       <= '0;
      blink_on <= 1'b1;
      an       <= 4'b1111;
      seg      <= SEG_BLANK;
      dp       <= 1'b1;
    end else begin
      sec_q   <= seconds;
      score_q <= score;
      go_q    <= game_over;
      if (c == C_LAST) begin
        c <= '0;
        d <= d - 2'd1;
      end else begin
        c <= c + CW'(1);
      end
      if (!go_q) begin
        bc       <= '0;
        blink_on <= 1'b1;
      end else if (bc == B_LAST) begin
        bc       <= '0;
        blink_on <= ~blink_on;
      end else begin
        bc <= bc + BW'(1);
      end
      an  <= an_nx;
      seg <= seg_nx;
      dp  <= dp_nx;
    end
  end

endmodule

// File: tb/tb_score_time_display.sv
// Bench for score_time_display: table-driven scan vectors fed through a
// scoreboard queue, plus hand sequences for blink, reset and mid-slot changes.
module tb_score_time_display;

  localparam int RC = 4;
  localparam int BC = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] seconds;
  logic       game_over;
  logic [6:0] score;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  score_time_display #(.REFRESH_CYCLES(RC), .BLINK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .seconds(seconds), .game_over(game_over),
    .score(score), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] sec;
    logic [6:0] scr;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    bit         cseg;
    bit         cdp;
    string      nm;
  } exp_t;

  vec_t tbl[16];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(logic [3:0] a, logic [6:0] s, logic p, string nm);
    exp_t e;
    e.an = a; e.seg = s; e.dp = p; e.cseg = 1'b1; e.cdp = 1'b1; e.nm = nm;
    return e;
  endfunction

  // Edge n counts from 1 at the first edge after reset release; each slot lasts RC edges.
  function automatic exp_t from_tbl(int base, int n, bit dark, string nm);
    exp_t e;
    int   p;
    p = ((n - 1) / RC) % 4;
    e = mk(tbl[base+p].an, tbl[base+p].seg, tbl[base+p].dp, nm);
    if (dark && p < 2) begin
      e.an  = 4'b1111;
      e.seg = 7'h7F;
      e.cdp = 1'b0;
    end
    return e;
  endfunction

  // game_over first seen at edge r: blink_on drops at edge r+BC, visible one edge later.
  function automatic bit is_dark(int n, int r);
    if (n < r + BC + 1) return 1'b0;
    return (((n - r - BC - 1) / BC) % 2) == 0;
  endfunction

  task automatic check_out();
    exp_t e;
    e = sbq.pop_front();
    checks++;
    if (an !== e.an || (e.cseg && seg !== e.seg) || (e.cdp && dp !== e.dp)) begin
      errors++;
      $display("FAIL %s @%0t: an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
               e.nm, $time, an, seg, dp, e.an, e.seg, e.dp);
    end
  endtask

  task automatic step(input exp_t e);
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic bare();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [4:0] s, input logic [6:0] sc, input logic go);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seconds   = 5'($urandom_range(0, 31));
      score     = 7'($urandom_range(0, 127));
      game_over = 1'($urandom_range(0, 1));
      step(mk(4'b1111, 7'h7F, 1'b1, "reset"));
    end
    seconds = s; score = sc; game_over = go; rst_n = 1'b1;
    // Input regs were cleared, so the first digit shows a blanked zero tens.
    step(mk(4'b0111, 7'h7F, 1'b1, "release"));
  endtask

  initial begin
    tbl[0]  = '{5'd29, 7'd7,   4'b0111, 7'h24, 1'b1};
    tbl[1]  = '{5'd29, 7'd7,   4'b1011, 7'h10, 1'b0};
    tbl[2]  = '{5'd29, 7'd7,   4'b1101, 7'h7F, 1'b1};
    tbl[3]  = '{5'd29, 7'd7,   4'b1110, 7'h78, 1'b1};
    tbl[4]  = '{5'd5,  7'd123, 4'b0111, 7'h7F, 1'b1};
    tbl[5]  = '{5'd5,  7'd123, 4'b1011, 7'h12, 1'b0};
    tbl[6]  = '{5'd5,  7'd123, 4'b1101, 7'h10, 1'b1};
    tbl[7]  = '{5'd5,  7'd123, 4'b1110, 7'h10, 1'b1};
    tbl[8]  = '{5'd0,  7'd42,  4'b0111, 7'h7F, 1'b1};
    tbl[9]  = '{5'd0,  7'd42,  4'b1011, 7'h40, 1'b0};
    tbl[10] = '{5'd0,  7'd42,  4'b1101, 7'h19, 1'b1};
    tbl[11] = '{5'd0,  7'd42,  4'b1110, 7'h24, 1'b1};
    tbl[12] = '{5'd31, 7'd99,  4'b0111, 7'h30, 1'b1};
    tbl[13] = '{5'd31, 7'd99,  4'b1011, 7'h79, 1'b0};
    tbl[14] = '{5'd31, 7'd99,  4'b1101, 7'h10, 1'b1};
    tbl[15] = '{5'd31, 7'd99,  4'b1110, 7'h10, 1'b1};

    rst_n = 1'b0; seconds = '0; score = '0; game_over = 1'b0;

    // Steady scans for each table scenario, two full rotations.
    for (int s = 0; s < 4; s++) begin
      do_reset(tbl[4*s].sec, tbl[4*s].scr, 1'b0);
      for (int n = 2; n <= 33; n++) step(from_tbl(4*s, n, 1'b0, "scan"));
    end

    // Seconds 29->28 during the seconds-ones slot.
    do_reset(5'd29, 7'd7, 1'b0);
    for (int n = 2; n <= 5; n++) step(from_tbl(0, n, 1'b0, "pre_change"));
    seconds = 5'd28;
    step(mk(4'b1011, 7'h10, 1'b0, "change_e1"));
    step(mk(4'b1011, 7'h00, 1'b0, "change_e2"));
    step(mk(4'b1011, 7'h00, 1'b0, "change_e3"));

    // Blink aligned so dark phases cover the seconds pair; drop mid dark phase.
    do_reset(5'd0, 7'd42, 1'b0);
    for (int n = 2; n <= 70; n++) begin
      if (n == 24) game_over = 1'b1;
      if (n == 51) game_over = 1'b0;
      if (n == 51 || n == 52) bare();
      else step(from_tbl(8, n, (n < 51) && is_dark(n, 24), "blink"));
    end

    // Reset in the dark phase while the score tens digit is selected.
    do_reset(5'd0, 7'd42, 1'b0);
    for (int n = 2; n <= 27; n++) begin
      if (n == 18) game_over = 1'b1;
      step(from_tbl(8, n, is_dark(n, 18), "blink2"));
    end
    rst_n = 1'b0;
    step(mk(4'b1111, 7'h7F, 1'b1, "rst_dark"));
    rst_n = 1'b1;
    step(mk(4'b0111, 7'h7F, 1'b1, "restart"));
    for (int n = 2; n <= 24; n++) step(from_tbl(8, n, is_dark(n, 1), "restart_blink"));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
